// File: rtl/dds_sweep_gen_if.sv
// Control, tuning and sample-output bundle for the DDS sweep generator.
// The master drives control and tuning inputs; the generator is the slave.
interface dds_sweep_gen_if #(
    parameter int FREQ_W  = 12,
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
);
    logic                      en;
    logic [1:0]                mode;
    logic                      start;
    logic                      abort;
    logic [FREQ_W-1:0]         freq_start;
    logic [FREQ_W-1:0]         freq_stop;
    logic [FREQ_W-1:0]         freq_step;
    logic [DWELL_W-1:0]        dwell;
    logic [PHASE_W-1:0]        phase;
    logic signed [OUT_W-1:0]   out;
    logic                      out_valid;
    logic [FREQ_W-1:0]         cur_freq;
    logic                      sweep_busy;
    logic                      sweep_done;

    modport master (
        output en, mode, start, abort, freq_start, freq_stop, freq_step, dwell, phase,
        input  out, out_valid, cur_freq, sweep_busy, sweep_done
    );

    modport slave (
        input  en, mode, start, abort, freq_start, freq_stop, freq_step, dwell, phase,
        output out, out_valid, cur_freq, sweep_busy, sweep_done
    );
endinterface

// File: rtl/dds_sweep_gen.sv
// DDS sine generator: phase accumulator, quarter-wave ROM, 3-stage output pipe,
// and a sweep FSM that steps the tuning word in fixed, single-ramp or triangle mode.
//
// state | meaning
// IDLE  | no sweep; mode 0 tracks freq_start, modes 1/2 hold cur_freq
// UP    | stepping cur_freq toward freq_stop once per dwell
// DOWN  | stepping cur_freq toward freq_start once per dwell (triangle only)
module dds_sweep_gen #(
    parameter int ACC_W   = 16,
    parameter int FREQ_W  = 12,
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    dds_sweep_gen_if.slave bus
);
    localparam int N     = 2 ** (PHASE_W - 2);
    localparam int MAG_W = OUT_W - 1;
    localparam int IDX_W = PHASE_W - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    // Elaboration-time sine via fixed-point Taylor series (scale 2^30), rounded to nearest.
    function automatic logic [MAG_W-1:0] lut_entry(input int i);
        longint scale, x, term, sum, amp, val;
        scale = 64'sd1 <<< 30;
        x     = (64'sd3373259426 * longint'(i)) / longint'(2 * N);
        term  = x;
        sum   = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((((term * x) / scale) * x) / scale) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
        val = (amp * sum + scale / 2) / scale;
        if (val > amp) val = amp;
        if (val < 0)   val = 0;
        return MAG_W'(val);
    endfunction

    logic [MAG_W-1:0] lut [0:N];
    for (genvar gi = 0; gi <= N; gi++) begin : g_lut
        localparam logic [MAG_W-1:0] LUT_V = lut_entry(gi);
        assign lut[gi] = LUT_V;
    end

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [PHASE_W-1:0]      addr_q, addr_d;
    logic [MAG_W-1:0]        mag_q, mag_d;
    logic                    neg_q, neg_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic [2:0]              vld_q, vld_d;
    logic [IDX_W-1:0]        lut_idx;
    logic signed [OUT_W-1:0] mag_s;

    state_t                  state_q, state_d;
    logic [FREQ_W-1:0]       cur_freq_q, cur_freq_d;
    logic [DWELL_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic                    done_q, done_d;

    logic [FREQ_W-1:0]       step_eff;
    logic [DWELL_W-1:0]      dwell_last;
    logic [FREQ_W:0]         up_sum, rs_sum;
    logic [FREQ_W-1:0]       up_freq, dn_freq, rs_freq;
    logic                    sweep_mode, expire;

    always_comb begin
        acc_d  = acc_q;
        addr_d = addr_q;
        mag_d  = mag_q;
        neg_d  = neg_q;
        out_d  = out_q;
        // Quadrants 1 and 3 read the quarter-wave table backwards.
        lut_idx = addr_q[PHASE_W-2] ? (IDX_W'(N) - {1'b0, addr_q[PHASE_W-3:0]})
                                    : {1'b0, addr_q[PHASE_W-3:0]};
        mag_s   = {1'b0, mag_q};
        if (bus.en) begin
            acc_d  = acc_q + ACC_W'(cur_freq_q);
            addr_d = acc_q[ACC_W-1 -: PHASE_W] + bus.phase;
            mag_d  = lut[lut_idx];
            neg_d  = addr_q[PHASE_W-1];
            out_d  = neg_q ? -mag_s : mag_s;
        end
        vld_d = {vld_q[1:0], bus.en};
    end

    always_comb begin
        step_eff   = (bus.freq_step == '0) ? FREQ_W'(1) : bus.freq_step;
        dwell_last = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
        up_sum     = {1'b0, cur_freq_q} + {1'b0, step_eff};
        up_freq    = (up_sum > {1'b0, bus.freq_stop}) ? bus.freq_stop : up_sum[FREQ_W-1:0];
        rs_sum     = {1'b0, bus.freq_start} + {1'b0, step_eff};
        rs_freq    = (rs_sum > {1'b0, bus.freq_stop}) ? bus.freq_stop : rs_sum[FREQ_W-1:0];
        dn_freq    = ({1'b0, cur_freq_q} < rs_sum) ? bus.freq_start : cur_freq_q - step_eff;
        sweep_mode = (bus.mode == 2'd1) || (bus.mode == 2'd2);
        expire     = bus.en && (dwell_cnt_q == dwell_last);

        state_d     = state_q;
        cur_freq_d  = cur_freq_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sweep_mode) begin
                        cur_freq_d = bus.freq_start;
                    end else if (bus.start) begin
                        cur_freq_d  = bus.freq_start;
                        dwell_cnt_d = '0;
                        if (bus.freq_start < bus.freq_stop) state_d = UP;
                        else                                done_d  = 1'b1;
                    end
                end
                UP, DOWN: begin
                    if (expire) begin
                        dwell_cnt_d = '0;
                        // Mode changes mid-sweep are only honoured here; 0/3 end the sweep.
                        if (!sweep_mode) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (state_q == UP) begin
                            if (cur_freq_q < bus.freq_stop) begin
                                cur_freq_d = up_freq;
                            end else if (bus.mode == 2'd1) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d    = DOWN;
                                cur_freq_d = dn_freq;
                            end
                        end else begin
                            if (cur_freq_q > bus.freq_start) begin
                                cur_freq_d = dn_freq;
                            end else begin
                                state_d    = UP;
                                cur_freq_d = rs_freq;
                            end
                        end
                    end else if (bus.en) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            addr_q      <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            vld_q       <= '0;
            state_q     <= IDLE;
            cur_freq_q  <= '0;
            dwell_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            vld_q       <= vld_d;
            state_q     <= state_d;
            cur_freq_q  <= cur_freq_d;
            dwell_cnt_q <= dwell_cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_valid  = vld_q[2];
    assign bus.cur_freq   = cur_freq_q;
    assign bus.sweep_busy = (state_q != IDLE);
    assign bus.sweep_done = done_q;
endmodule

// File: tb/tb_dds_sweep_gen.sv
// Directed bench for dds_sweep_gen: reset, tone, phase offset, sweeps, gating, corners.
module tb_dds_sweep_gen;
    localparam int ACC_W   = 16;
    localparam int FREQ_W  = 12;
    localparam int PHASE_W = 8;
    localparam int OUT_W   = 8;
    localparam int DWELL_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    dds_sweep_gen_if #(.FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)) bus ();

    dds_sweep_gen #(
        .ACC_W(ACC_W), .FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.mode = 2'd0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.freq_start = '0; bus.freq_stop = '0; bus.freq_step = '0;
        bus.dwell = '0; bus.phase = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1; bus.en = 1'b1;
        step_clk(2);
        rst = 1'b0; bus.en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.mode = 2'd0; bus.freq_start = 12'd256;
        rst = 1'b1; bus.en = 1'b1;
        step_clk(2);
        n_tests++; if (bus.out !== 8'sd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", bus.out); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.cur_freq !== 12'd0) begin n_fail++; $display("FAIL reset_cur_freq: got %0d want 0", bus.cur_freq); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.sweep_busy); end
        n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.sweep_done); end
        rst = 1'b0;
    endtask

    task automatic test_fixed_tone();
        int chk_cyc [8];
        int chk_val [8];
        logic signed [OUT_W-1:0] exp_o;
        chk_cyc = '{3, 4, 5, 6, 35, 67, 131, 195};
        chk_val = '{0, 3, 6, 9, 90, 127, 0, -127};
        do_reset();
        bus.mode = 2'd0; bus.freq_start = 12'd256;
        step_clk(1);
        n_tests++; if (bus.cur_freq !== 12'd256) begin n_fail++; $display("FAIL tone_cur_freq: got %0d want 256", bus.cur_freq); end
        bus.en = 1'b1;
        for (int k = 1; k <= 195; k++) begin
            step_clk(1);
            if (k == 2) begin
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL tone_valid_early: got %b want 0", bus.out_valid); end
            end
            if (k == 3) begin
                n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL tone_valid_rise: got %b want 1", bus.out_valid); end
            end
            for (int i = 0; i < 8; i++) begin
                if (chk_cyc[i] == k) begin
                    exp_o = OUT_W'(chk_val[i]);
                    n_tests++;
                    if (bus.out !== exp_o) begin
                        n_fail++; $display("FAIL tone_out[cycle %0d]: got %0d want %0d", k, bus.out, exp_o);
                    end
                end
            end
        end
    endtask

    task automatic test_phase_offset();
        do_reset();
        bus.mode = 2'd0; bus.freq_start = 12'd0; bus.phase = 8'd64; bus.en = 1'b1;
        step_clk(3);
        n_tests++; if (bus.out !== 8'sd127) begin n_fail++; $display("FAIL phase64_out: got %0d want 127", bus.out); end
        step_clk(3);
        n_tests++; if (bus.out !== 8'sd127) begin n_fail++; $display("FAIL phase64_hold: got %0d want 127", bus.out); end
        bus.phase = 8'd192;
        step_clk(2);
        n_tests++; if (bus.out !== 8'sd127) begin n_fail++; $display("FAIL phase192_latency: got %0d want 127", bus.out); end
        step_clk(1);
        n_tests++; if (bus.out !== -8'sd127) begin n_fail++; $display("FAIL phase192_out: got %0d want -127", bus.out); end
    endtask

    task automatic test_single_sweep();
        logic [FREQ_W-1:0] exp_f;
        do_reset();
        bus.mode = 2'd1; bus.freq_start = 12'd100; bus.freq_stop = 12'd130;
        bus.freq_step = 12'd10; bus.dwell = 8'd4; bus.en = 1'b1; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        for (int m = 0; m < 16; m++) begin
            if (m > 0) step_clk(1);
            exp_f = FREQ_W'(100 + 10 * (m / 4));
            n_tests++; if (bus.cur_freq !== exp_f) begin n_fail++; $display("FAIL single_cur_freq[%0d]: got %0d want %0d", m, bus.cur_freq, exp_f); end
            n_tests++; if (bus.sweep_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want 1", m, bus.sweep_busy); end
            n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL single_done_early[%0d]: got %b want 0", m, bus.sweep_done); end
        end
        step_clk(1);
        n_tests++; if (bus.sweep_done !== 1'b1) begin n_fail++; $display("FAIL single_done_pulse: got %b want 1", bus.sweep_done); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", bus.sweep_busy); end
        n_tests++; if (bus.cur_freq !== 12'd130) begin n_fail++; $display("FAIL single_end_freq: got %0d want 130", bus.cur_freq); end
        step_clk(1);
        n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", bus.sweep_done); end
        n_tests++; if (bus.cur_freq !== 12'd130) begin n_fail++; $display("FAIL single_hold_freq: got %0d want 130", bus.cur_freq); end
    endtask

    task automatic test_triangle();
        int seq [8];
        logic [FREQ_W-1:0] exp_f;
        seq = '{100, 115, 120, 105, 100, 115, 120, 105};
        do_reset();
        bus.mode = 2'd2; bus.freq_start = 12'd100; bus.freq_stop = 12'd120;
        bus.freq_step = 12'd15; bus.dwell = 8'd2; bus.en = 1'b1; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        for (int m = 0; m < 16; m++) begin
            if (m > 0) step_clk(1);
            exp_f = FREQ_W'(seq[m / 2]);
            n_tests++; if (bus.cur_freq !== exp_f) begin n_fail++; $display("FAIL tri_cur_freq[%0d]: got %0d want %0d", m, bus.cur_freq, exp_f); end
            n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL tri_done[%0d]: got %b want 0", m, bus.sweep_done); end
            n_tests++; if (bus.sweep_busy !== 1'b1) begin n_fail++; $display("FAIL tri_busy[%0d]: got %b want 1", m, bus.sweep_busy); end
        end
        bus.abort = 1'b1;
        step_clk(1);
        bus.abort = 1'b0;
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.sweep_busy); end
        n_tests++; if (bus.cur_freq !== 12'd105) begin n_fail++; $display("FAIL abort_freq: got %0d want 105", bus.cur_freq); end
        n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", bus.sweep_done); end
        step_clk(1);
        n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL abort_done_late: got %b want 0", bus.sweep_done); end
        n_tests++; if (bus.cur_freq !== 12'd105) begin n_fail++; $display("FAIL abort_freq_hold: got %0d want 105", bus.cur_freq); end
    endtask

    task automatic test_enable_gating();
        do_reset();
        bus.mode = 2'd1; bus.freq_start = 12'd2048; bus.freq_stop = 12'd2100;
        bus.freq_step = 12'd10; bus.dwell = 8'd4; bus.en = 1'b1; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        step_clk(4);
        n_tests++; if (bus.cur_freq !== 12'd2058) begin n_fail++; $display("FAIL gate_pre_freq: got %0d want 2058", bus.cur_freq); end
        n_tests++; if (bus.out !== 8'sd25) begin n_fail++; $display("FAIL gate_pre_out: got %0d want 25", bus.out); end
        bus.en = 1'b0;
        for (int l = 1; l <= 5; l++) begin
            step_clk(1);
            n_tests++; if (bus.cur_freq !== 12'd2058) begin n_fail++; $display("FAIL gate_freq[%0d]: got %0d want 2058", l, bus.cur_freq); end
            n_tests++; if (bus.out !== 8'sd25) begin n_fail++; $display("FAIL gate_out[%0d]: got %0d want 25", l, bus.out); end
            if (l >= 3) begin
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_valid[%0d]: got %b want 0", l, bus.out_valid); end
            end
        end
        bus.en = 1'b1;
        step_clk(1);
        n_tests++; if (bus.out !== 8'sd49) begin n_fail++; $display("FAIL resume_out1: got %0d want 49", bus.out); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL resume_valid1: got %b want 0", bus.out_valid); end
        step_clk(1);
        n_tests++; if (bus.out !== 8'sd71) begin n_fail++; $display("FAIL resume_out2: got %0d want 71", bus.out); end
        step_clk(1);
        n_tests++; if (bus.out !== 8'sd90) begin n_fail++; $display("FAIL resume_out3: got %0d want 90", bus.out); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid3: got %b want 1", bus.out_valid); end
        n_tests++; if (bus.cur_freq !== 12'd2058) begin n_fail++; $display("FAIL resume_freq3: got %0d want 2058", bus.cur_freq); end
        step_clk(1);
        n_tests++; if (bus.cur_freq !== 12'd2068) begin n_fail++; $display("FAIL resume_freq4: got %0d want 2068", bus.cur_freq); end

        bus.abort = 1'b1;
        step_clk(1);
        bus.abort = 1'b0;
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL gate_abort_busy: got %b want 0", bus.sweep_busy); end
        bus.freq_start = 12'd200; bus.freq_stop = 12'd150; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        n_tests++; if (bus.sweep_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", bus.sweep_done); end
        n_tests++; if (bus.cur_freq !== 12'd200) begin n_fail++; $display("FAIL empty_freq: got %0d want 200", bus.cur_freq); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b want 0", bus.sweep_busy); end
        step_clk(1);
        n_tests++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL empty_done_width: got %b want 0", bus.sweep_done); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_late: got %b want 0", bus.sweep_busy); end
    endtask

    task automatic test_zero_params();
        do_reset();
        bus.mode = 2'd1; bus.freq_start = 12'd10; bus.freq_stop = 12'd12;
        bus.freq_step = 12'd0; bus.dwell = 8'd0; bus.en = 1'b1; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        n_tests++; if (bus.cur_freq !== 12'd10) begin n_fail++; $display("FAIL zero_freq0: got %0d want 10", bus.cur_freq); end
        step_clk(1);
        n_tests++; if (bus.cur_freq !== 12'd11) begin n_fail++; $display("FAIL zero_freq1: got %0d want 11", bus.cur_freq); end
        step_clk(1);
        n_tests++; if (bus.cur_freq !== 12'd12) begin n_fail++; $display("FAIL zero_freq2: got %0d want 12", bus.cur_freq); end
        n_tests++; if (bus.sweep_busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", bus.sweep_busy); end
        step_clk(1);
        n_tests++; if (bus.sweep_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", bus.sweep_done); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_fall: got %b want 0", bus.sweep_busy); end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        bus.mode = 2'd2; bus.freq_start = 12'd10; bus.freq_stop = 12'd50;
        bus.freq_step = 12'd5; bus.dwell = 8'd3; bus.en = 1'b1; bus.start = 1'b1;
        step_clk(1);
        bus.start = 1'b0;
        step_clk(4);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        step_clk(1);
        rst = 1'b0;
        n_tests++; if (bus.cur_freq !== 12'd0) begin n_fail++; $display("FAIL midrst_freq: got %0d want 0", bus.cur_freq); end
        n_tests++; if (bus.sweep_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.sweep_busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out !== 8'sd0) begin n_fail++; $display("FAIL midrst_out: got %0d want 0", bus.out); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fixed_tone();
        test_phase_offset();
        test_single_sweep();
        test_triangle();
        test_enable_gating();
        test_zero_params();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
